rr_mux_select_arbiter: RTL

- Sequential select generator sitting directly upstream of the 4-to-1 mux; its sel output drives the mux select s[1:0].
- Arbitrates four request lines round-robin and holds the granted channel until release or timeout.
- Publishes a one-hot grant and a valid flag so the consumer knows which channel's data is on the mux output.

---
 rtl/rr_mux_select_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin select generator for a 4:1 mux; holds each grant until release or timeout.
// Latency: 1 cycle from req sampled high to grant_valid; 0-bubble handover between owners.
// Backpressure: owner holds the mux until done, withdrawal of req, or HOLD_MAX cycles elapse.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[3:0]    per-channel request
//   done        owner release strobe (ignored while idle)
//   sel[1:0]    registered mux select, index of current/last owner
//   grant[3:0]  registered one-hot grant, zero when idle
//   grant_valid high while a grant is held (== |grant)
//   preempt     one-cycle pulse after a grant ends by timeout
module rr_mux_select_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Counter value on the last cycle of a full-length grant.
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

    state_t             r_state;
    logic   [1:0]       r_last;
    logic   [1:0]       r_sel;
    logic   [3:0]       r_grant;
    logic               r_preempt;
    logic   [CNT_W-1:0] r_cnt;

    state_t             w_state_n;
    logic   [1:0]       w_last_n;
    logic   [1:0]       w_sel_n;
    logic   [3:0]       w_grant_n;
    logic               w_preempt_n;
    logic   [CNT_W-1:0] w_cnt_n;

    logic               w_owner_req;
    logic               w_timeout;
    logic               w_release;
    logic               w_to_only;
    logic   [3:0]       w_others;
    logic   [3:0]       w_search_req;
    logic   [1:0]       w_search_last;
    logic   [1:0]       w_winner;

    // First requester in order last+1, last+2, last+3, last. Scanning from the
    // far end and overwriting lets the nearest candidate win.
    function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] res;
        res = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (rq[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_owner_req   = req[r_sel];
        w_timeout     = (HOLD_MAX != 0) && (r_cnt == HOLD_LAST);
        w_release     = done || !w_owner_req || w_timeout;
        // Timeout counts as the cause only when neither done nor withdrawal applies.
        w_to_only     = w_timeout && !done && w_owner_req;
        w_others      = req & ~(4'b0001 << r_sel);
        // A timed-out owner steps aside unless nobody else is asking.
        w_search_req  = (r_state == S_GRANT && w_to_only && (w_others != 4'b0000)) ? w_others : req;
        // On release the pointer moves to the releasing owner in the same cycle.
        w_search_last = (r_state == S_GRANT) ? r_sel : r_last;
        w_winner      = rr_pick(w_search_req, w_search_last);
    end

    always_comb begin
        w_state_n   = r_state;
        w_last_n    = r_last;
        w_sel_n     = r_sel;
        w_grant_n   = r_grant;
        w_preempt_n = 1'b0;
        w_cnt_n     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    w_state_n = S_GRANT;
                    w_sel_n   = w_winner;
                    w_grant_n = 4'b0001 << w_winner;
                    w_cnt_n   = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_last_n    = r_sel;
                    w_preempt_n = w_to_only;
                    w_cnt_n     = '0;
                    if (w_search_req != 4'b0000) begin
                        w_sel_n   = w_winner;
                        w_grant_n = 4'b0001 << w_winner;
                    end else begin
                        w_state_n = S_IDLE;
                        w_grant_n = 4'b0000;
                    end
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_grant_n = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= 2'd3;
            r_sel     <= 2'd0;
            r_grant   <= 4'b0000;
            r_preempt <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_last    <= w_last_n;
            r_sel     <= w_sel_n;
            r_grant   <= w_grant_n;
            r_preempt <= w_preempt_n;
            r_cnt     <= w_cnt_n;
        end
    end

    assign sel         = r_sel;
    assign grant       = r_grant;
    assign grant_valid = (r_state == S_GRANT);
    assign preempt     = r_preempt;

endmodule
